// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO (Clause 22) management responder.
// Holds the frame field patterns and widths. It also holds the state type
// used by the responder FSM.
package mdio_pkg;

    // Opcode, start and write-turnaround patterns, MSB first on the wire
    localparam logic [1:0] OP_READ    = 2'b10;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] ST_PATTERN = 2'b01;
    localparam logic [1:0] TA_WRITE   = 2'b10;

    // Field widths of a Clause 22 frame
    localparam int OP_W    = 2;
    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int DATA_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST2,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_RDATA,
        S_WDATA
    } mdio_state_t;

endpackage

// File: rtl/mdio_sync_edge.sv
// Synchroniser and MDC rising-edge detector for the MDIO responder.
// Ports:
//   clock       system clock
//   reset       synchronous, active-high
//   mdc_i       raw MDC from the master (asynchronous)
//   mdio_i      raw MDIO pad input (asynchronous)
//   mdc_rise_o  one-clock pulse on a synchronised MDC 0->1 transition
//   mdio_o      synchronised MDIO
module mdio_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic mdc_i,
    input  logic mdio_i,
    output logic mdc_rise_o,
    output logic mdio_o
);

    logic [SYNC_STAGES-1:0] mdcSync_q;
    logic [SYNC_STAGES-1:0] mdioSync_q;
    logic                   mdcPrev_q;

    // Both lines pass through the same number of flops. The relative MDC/MDIO
    // timing seen by the master is therefore preserved. MDIO resets to its
    // idle (pulled-up) level.
    always_ff @(posedge clock) begin
        if (reset) begin
            mdcSync_q  <= '0;
            mdioSync_q <= '1;
            mdcPrev_q  <= 1'b0;
        end else begin
            mdcSync_q  <= {mdcSync_q[SYNC_STAGES-2:0], mdc_i};
            mdioSync_q <= {mdioSync_q[SYNC_STAGES-2:0], mdio_i};
            mdcPrev_q  <= mdcSync_q[SYNC_STAGES-1];
        end
    end

    assign mdc_rise_o = mdcSync_q[SYNC_STAGES-1] & ~mdcPrev_q;
    assign mdio_o     = mdioSync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mdio_responder.sv
// MDIO Clause 22 management responder (PHY side).
// Oversamples MDC/MDIO in the system clock domain. Decodes read and write
// frames addressed to PHY_ADDR and serves them from a local register bank.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   mdc_in, mdio_in       asynchronous management interface inputs
//   mdio_out, mdio_oe     pad drive value and output enable
//   reg_addr              register address of the current frame
//   reg_rd_en/reg_rd_data read strobe; data is expected one clock later
//   reg_wr_en/reg_wr_data write strobe with the assembled data word
//   frame_err             pulse on a malformed write turnaround to us
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR     = 5'd7,
    parameter int         PREAMBLE_MIN = 32,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mdc_in,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic [4:0]  reg_addr,
    output logic        reg_rd_en,
    input  logic [15:0] reg_rd_data,
    output logic        reg_wr_en,
    output logic [15:0] reg_wr_data,
    output logic        frame_err
);

    // One spare count value keeps the counter wide enough for PREAMBLE_MIN=0
    localparam int CNT_W = $clog2(PREAMBLE_MIN + 2);
    localparam logic [CNT_W-1:0] PRE_MIN = CNT_W'(PREAMBLE_MIN);

    logic mdcRise;
    logic mdioBit;

    mdio_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock     (clock),
        .reset     (reset),
        .mdc_i     (mdc_in),
        .mdio_i    (mdio_in),
        .mdc_rise_o(mdcRise),
        .mdio_o    (mdioBit)
    );

    mdio_state_t        state_q,   state_d;
    logic [3:0]         bitCnt_q,  bitCnt_d;
    logic [CNT_W-1:0]   preCnt_q,  preCnt_d;
    logic [DATA_W-1:0]  shift_q,   shift_d;
    logic               isRead_q,  isRead_d;
    logic               oe_q,      oe_d;
    logic               out_q,     out_d;
    logic [REGAD_W-1:0] regAddr_q, regAddr_d;
    logic               rdEn_q,    rdEn_d;
    logic               rdCap_q,   rdCap_d;
    logic               wrEn_q,    wrEn_d;
    logic [DATA_W-1:0]  wrData_q,  wrData_d;
    logic               err_q,     err_d;

    // Next-state logic. Frame bits are sampled only on MDC edge cycles.
    // The read-data capture runs off the strobe pipeline between edges.
    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        preCnt_d  = preCnt_q;
        shift_d   = shift_q;
        isRead_d  = isRead_q;
        oe_d      = oe_q;
        out_d     = out_q;
        regAddr_d = regAddr_q;
        rdEn_d    = 1'b0;
        rdCap_d   = rdEn_q;
        wrEn_d    = 1'b0;
        wrData_d  = wrData_q;
        err_d     = 1'b0;

        // Bank data is valid the clock after the strobe. The strobe is issued
        // well before the next MDC edge, so this never collides with a shift.
        if (rdCap_q) begin
            shift_d = reg_rd_data;
        end

        if (mdcRise) begin
            case (state_q)
                S_IDLE: begin
                    if (mdioBit) begin
                        if (preCnt_q < PRE_MIN) begin
                            preCnt_d = preCnt_q + CNT_W'(1);
                        end
                    end else begin
                        if (preCnt_q >= PRE_MIN) begin
                            state_d = S_ST2;
                        end
                        preCnt_d = '0;
                    end
                end
                S_ST2: begin
                    bitCnt_d = 4'd0;
                    state_d  = (mdioBit == ST_PATTERN[0]) ? S_OP : S_IDLE;
                end
                S_OP: begin
                    shift_d  = {shift_q[DATA_W-2:0], mdioBit};
                    bitCnt_d = bitCnt_q + 4'd1;
                    if (bitCnt_q == 4'(OP_W - 1)) begin
                        bitCnt_d = 4'd0;
                        isRead_d = ({shift_q[0], mdioBit} == OP_READ);
                        if ({shift_q[0], mdioBit} == OP_READ ||
                            {shift_q[0], mdioBit} == OP_WRITE) begin
                            state_d = S_PHYAD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_PHYAD: begin
                    shift_d  = {shift_q[DATA_W-2:0], mdioBit};
                    bitCnt_d = bitCnt_q + 4'd1;
                    if (bitCnt_q == 4'(PHYAD_W - 1)) begin
                        bitCnt_d = 4'd0;
                        state_d  = ({shift_q[3:0], mdioBit} == PHY_ADDR) ? S_REGAD : S_IDLE;
                    end
                end
                S_REGAD: begin
                    shift_d  = {shift_q[DATA_W-2:0], mdioBit};
                    bitCnt_d = bitCnt_q + 4'd1;
                    if (bitCnt_q == 4'(REGAD_W - 1)) begin
                        bitCnt_d  = 4'd0;
                        regAddr_d = {shift_q[3:0], mdioBit};
                        rdEn_d    = isRead_q;
                        state_d   = S_TA;
                    end
                end
                S_TA: begin
                    if (isRead_q) begin
                        // TA1 edge grabs the pad and drives TA2 low.
                        // The TA2 edge drives the first data bit.
                        if (bitCnt_q == 4'd0) begin
                            oe_d     = 1'b1;
                            out_d    = 1'b0;
                            bitCnt_d = 4'd1;
                        end else begin
                            out_d    = shift_q[DATA_W-1];
                            shift_d  = {shift_q[DATA_W-2:0], 1'b0};
                            bitCnt_d = 4'd0;
                            state_d  = S_RDATA;
                        end
                    end else if (bitCnt_q == 4'd0) begin
                        if (mdioBit == TA_WRITE[1]) begin
                            bitCnt_d = 4'd1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        bitCnt_d = 4'd0;
                        if (mdioBit == TA_WRITE[0]) begin
                            state_d = S_WDATA;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                S_RDATA: begin
                    // The 16th edge here is the one on which the master
                    // samples data[0]. The pad is released on that edge.
                    bitCnt_d = bitCnt_q + 4'd1;
                    if (bitCnt_q == 4'd15) begin
                        oe_d    = 1'b0;
                        out_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        out_d   = shift_q[DATA_W-1];
                        shift_d = {shift_q[DATA_W-2:0], 1'b0};
                    end
                end
                S_WDATA: begin
                    shift_d  = {shift_q[DATA_W-2:0], mdioBit};
                    bitCnt_d = bitCnt_q + 4'd1;
                    if (bitCnt_q == 4'd15) begin
                        wrData_d = {shift_q[DATA_W-2:0], mdioBit};
                        wrEn_d   = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bitCnt_q  <= '0;
            preCnt_q  <= '0;
            shift_q   <= '0;
            isRead_q  <= 1'b0;
            oe_q      <= 1'b0;
            out_q     <= 1'b1;
            regAddr_q <= '0;
            rdEn_q    <= 1'b0;
            rdCap_q   <= 1'b0;
            wrEn_q    <= 1'b0;
            wrData_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            preCnt_q  <= preCnt_d;
            shift_q   <= shift_d;
            isRead_q  <= isRead_d;
            oe_q      <= oe_d;
            out_q     <= out_d;
            regAddr_q <= regAddr_d;
            rdEn_q    <= rdEn_d;
            rdCap_q   <= rdCap_d;
            wrEn_q    <= wrEn_d;
            wrData_q  <= wrData_d;
            err_q     <= err_d;
        end
    end

    assign mdio_out    = out_q;
    assign mdio_oe     = oe_q;
    assign reg_addr    = regAddr_q;
    assign reg_rd_en   = rdEn_q;
    assign reg_wr_en   = wrEn_q;
    assign reg_wr_data = wrData_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Self-checking bench for mdio_responder.
// Acts as the MDIO master. It bit-bangs MDC/MDIO frames and models a register
// bank, then predicts each frame's outcome from the Clause 22 frame rules.
// A second instance with preamble suppression covers the zero-preamble case.
module tb_mdio_responder;
    import mdio_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset   = 1'b1;
    logic mdcM    = 1'b0;
    logic mdioM   = 1'b1;
    logic useZero = 1'b0;

    logic [15:0] bankMem [32];
    logic [15:0] bankRd = 16'h0000;

    logic        mdcA, mdioA, outA, oeA, rdA, wrA, errA;
    logic [4:0]  addrA;
    logic [15:0] wrDataA;
    logic        mdcB, mdioB, outB, oeB, rdB, wrB, errB;
    logic [4:0]  addrB;
    logic [15:0] wrDataB;

    logic        oeS, outS, rdS, wrS, errS;
    logic [4:0]  addrS;
    logic [15:0] wrDataS;

    int assertCount = 0;
    int failCount   = 0;
    int rdTotal = 0, wrTotal = 0, errTotal = 0, oeTotal = 0;
    logic [4:0]  lastRdAddr = 5'd0, lastWrAddr = 5'd0;
    logic [15:0] lastWrData = 16'h0;

    assign mdcA  = useZero ? 1'b0 : mdcM;
    assign mdioA = useZero ? 1'b1 : mdioM;
    assign mdcB  = useZero ? mdcM : 1'b0;
    assign mdioB = useZero ? mdioM : 1'b1;

    assign oeS     = useZero ? oeB     : oeA;
    assign outS    = useZero ? outB    : outA;
    assign rdS     = useZero ? rdB     : rdA;
    assign wrS     = useZero ? wrB     : wrA;
    assign errS    = useZero ? errB    : errA;
    assign addrS   = useZero ? addrB   : addrA;
    assign wrDataS = useZero ? wrDataB : wrDataA;

    mdio_responder dut (
        .clock(clock), .reset(reset), .mdc_in(mdcA), .mdio_in(mdioA),
        .mdio_out(outA), .mdio_oe(oeA), .reg_addr(addrA),
        .reg_rd_en(rdA), .reg_rd_data(bankRd), .reg_wr_en(wrA),
        .reg_wr_data(wrDataA), .frame_err(errA)
    );

    mdio_responder #(.PREAMBLE_MIN(0)) dutZero (
        .clock(clock), .reset(reset), .mdc_in(mdcB), .mdio_in(mdioB),
        .mdio_out(outB), .mdio_oe(oeB), .reg_addr(addrB),
        .reg_rd_en(rdB), .reg_rd_data(bankRd), .reg_wr_en(wrB),
        .reg_wr_data(wrDataB), .frame_err(errB)
    );

    // Register bank model plus running event totals of the selected instance
    always @(negedge clock) begin
        if (rdS) begin
            rdTotal++;
            lastRdAddr = addrS;
            bankRd = bankMem[addrS];
        end
        if (wrS) begin
            wrTotal++;
            lastWrAddr = addrS;
            lastWrData = wrDataS;
        end
        if (errS) errTotal++;
        if (oeS)  oeTotal++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One MDC period: the master drives on the low phase and samples the pad
    // just before the rising edge
    task automatic sendBit(input logic b, output logic sampled);
        mdcM  = 1'b0;
        mdioM = b;
        repeat (8) @(negedge clock);
        sampled = oeS ? outS : mdioM;
        mdcM = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    task automatic applyStimulus(input int preLen, input logic [1:0] op,
                                 input logic [4:0] phy, input logic [4:0] regA,
                                 input logic [1:0] ta, input logic [15:0] wdata,
                                 input int abortBit,
                                 output logic ta2, output logic [15:0] rdBits);
        logic s;
        ta2    = 1'b0;
        rdBits = 16'h0;
        for (int i = 0; i < preLen; i++) sendBit(1'b1, s);
        sendBit(1'b0, s);
        sendBit(1'b1, s);
        for (int i = 1; i >= 0; i--) sendBit(op[i], s);
        for (int i = 4; i >= 0; i--) sendBit(phy[i], s);
        for (int i = 4; i >= 0; i--) sendBit(regA[i], s);
        if (op == OP_READ) begin
            sendBit(1'b1, s);
            sendBit(1'b1, ta2);
            for (int i = 15; i >= 0; i--) begin
                sendBit(1'b1, s);
                rdBits[i] = s;
                if (15 - i == abortBit) begin
                    reset = 1'b1;
                    @(negedge clock);
                    reset = 1'b0;
                    checkOutput("abort_oe_released", 32'(oeS), 32'd0);
                    break;
                end
            end
        end else begin
            sendBit(ta[1], s);
            sendBit(ta[0], s);
            for (int i = 15; i >= 0; i--) sendBit(wdata[i], s);
        end
        mdcM  = 1'b0;
        mdioM = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    // Reference model: predicts strobes and read data from the frame fields
    task automatic runAndCheck(input string tag, input int preLen, input int preMin,
                               input logic [1:0] op, input logic [4:0] phy,
                               input logic [4:0] regA, input logic [1:0] ta,
                               input logic [15:0] wdata);
        int rd0, wr0, err0, oe0;
        logic ta2;
        logic [15:0] rdBits;
        bit served, expRd, expWr, expErr;
        served = (preLen >= preMin) && (phy == 5'd7) && (op == 2'b10 || op == 2'b01);
        expRd  = served && (op == 2'b10);
        expWr  = served && (op == 2'b01) && (ta == 2'b10);
        expErr = served && (op == 2'b01) && (ta != 2'b10);
        rd0 = rdTotal; wr0 = wrTotal; err0 = errTotal; oe0 = oeTotal;
        applyStimulus(preLen, op, phy, regA, ta, wdata, -1, ta2, rdBits);
        checkOutput({tag, "_rd_strobes"}, 32'(rdTotal - rd0), 32'(expRd));
        checkOutput({tag, "_wr_strobes"}, 32'(wrTotal - wr0), 32'(expWr));
        checkOutput({tag, "_frame_err"}, 32'(errTotal - err0), 32'(expErr));
        checkOutput({tag, "_oe_after"}, 32'(oeS), 32'd0);
        if (expRd) begin
            checkOutput({tag, "_rd_addr"}, 32'(lastRdAddr), 32'(regA));
            checkOutput({tag, "_ta2"}, 32'(ta2), 32'd0);
            checkOutput({tag, "_rd_data"}, 32'(rdBits), 32'(bankMem[regA]));
        end else begin
            checkOutput({tag, "_oe_never"}, 32'(oeTotal - oe0), 32'd0);
        end
        if (expWr) begin
            checkOutput({tag, "_wr_addr"}, 32'(lastWrAddr), 32'(regA));
            checkOutput({tag, "_wr_data"}, 32'(lastWrData), 32'(wdata));
        end
    endtask

    initial begin
        logic ta2;
        logic [15:0] rdBits;
        logic [1:0]  op;
        logic [4:0]  phy;
        for (int i = 0; i < 32; i++) bankMem[i] = 16'($urandom);
        bankMem[2] = 16'h0141;

        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("reset_oe", 32'(oeA), 32'd0);
        checkOutput("reset_out", 32'(outA), 32'd1);
        checkOutput("reset_addr", 32'(addrA), 32'd0);
        checkOutput("reset_rd_en", 32'(rdA), 32'd0);
        checkOutput("reset_wr_en", 32'(wrA), 32'd0);
        checkOutput("reset_wr_data", 32'(wrDataA), 32'd0);
        checkOutput("reset_err", 32'(errA), 32'd0);

        runAndCheck("read_p7_r2", 32, 32, OP_READ, 5'd7, 5'd2, 2'b00, 16'h0);
        runAndCheck("write_p7_r0", 32, 32, OP_WRITE, 5'd7, 5'd0, 2'b10, 16'h8000);
        runAndCheck("read_p3_r1", 32, 32, OP_READ, 5'd3, 5'd1, 2'b00, 16'h0);

        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        runAndCheck("read_pre31", 31, 32, OP_READ, 5'd7, 5'd2, 2'b00, 16'h0);
        useZero = 1'b1;
        runAndCheck("read_nopre", 0, 0, OP_READ, 5'd7, 5'd2, 2'b00, 16'h0);
        useZero = 1'b0;

        applyStimulus(32, OP_READ, 5'd7, 5'd2, 2'b00, 16'h0, 8, ta2, rdBits);
        runAndCheck("read_after_abort", 32, 32, OP_READ, 5'd7, 5'd2, 2'b00, 16'h0);

        runAndCheck("write_ta00", 32, 32, OP_WRITE, 5'd7, 5'd5, 2'b00, 16'h1234);
        runAndCheck("write_after_err", 32, 32, OP_WRITE, 5'd7, 5'd5, 2'b10, 16'hBEEF);

        for (int n = 0; n < 8; n++) begin
            op  = 2'($urandom_range(0, 3));
            phy = ($urandom_range(0, 2) != 0) ? 5'd7 : 5'($urandom);
            runAndCheck($sformatf("rand%0d", n), 32 + int'($urandom_range(0, 6)), 32, op,
                        phy, 5'($urandom), ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b10,
                        16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
